rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8_pkg.sv | 18 +
 rtl/rr_arbiter8_if.sv | 31 +++
 rtl/rr_arbiter8_pick8.sv | 34 +++
 rtl/rr_arbiter8.sv | 103 ++++++++++
 tb/tb_rr_arbiter8.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDXW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Expand an owner index into its one-hot select vector.
    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDXW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;

    logic [rr_arbiter8_pkg::NREQ-1:0] req;
    logic                             done;
    logic [rr_arbiter8_pkg::NREQ-1:0] grant;
    logic [rr_arbiter8_pkg::IDXW-1:0] grant_idx;
    logic                             grant_valid;
    logic                             timeout;

    // Requester side: drives requests and the release strobe.
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );

endinterface

// File: rtl/rr_arbiter8_pick8.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] sel,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [IDXW-1:0] enc;

    // Rotate right by ptr so the highest-priority requester lands at bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[IDXW'(i) + ptr];
        end
    end

    // Fixed-priority encode of the lowest set bit, then undo the rotation.
    always_comb begin
        enc = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDXW'(i);
            end
        end
        sel = enc + ptr;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold timeout and one-cycle gap.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic            grant_valid_q, grant_valid_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] pick_sel;
    logic            pick_any;
    logic            release_c;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    assign release_c = bus.done | ~bus.req[grant_idx_q];

    // Next-state and next-output logic; outputs default low so GAP/IDLE are quiet.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = '0;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_idx_d   = pick_sel;
                    grant_d       = idx2onehot(pick_sel);
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (release_c) begin
                    ptr_d   = grant_idx_q + IDXW'(1);
                    state_d = ST_GAP;
                end else if (hold_cnt_q == CW'(HOLD_MAX - 1)) begin
                    ptr_d     = grant_idx_q + IDXW'(1);
                    timeout_d = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    hold_cnt_d    = hold_cnt_q + CW'(1);
                    grant_d       = grant_q;
                    grant_valid_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8.
module tb_rr_arbiter8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.HOLD_MAX(16), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0 ||
                bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0)
                $display("FAIL reset_outputs cyc %0d: grant=%h valid=%b idx=%0d to=%b, want 00/0/0/0",
                         i, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
            else n_pass++;
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.grant !== 8'h01 || bus.grant_idx !== 3'd0 || bus.grant_valid !== 1'b1)
            $display("FAIL first_grant: grant=%h idx=%0d valid=%b, want 01/0/1",
                     bus.grant, bus.grant_idx, bus.grant_valid);
        else n_pass++;
    endtask

    // Continues from test_reset: owner 0 holds the grant.
    task automatic test_rotation();
        logic [7:0] exp_oh;
        logic [2:0] exp_idx;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            n_checks++;
            if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0)
                $display("FAIL rot_gap k=%0d: grant=%h valid=%b to=%b, want 00/0/0",
                         k, bus.grant, bus.grant_valid, bus.timeout);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0)
                $display("FAIL rot_idle k=%0d: grant=%h valid=%b, want 00/0",
                         k, bus.grant, bus.grant_valid);
            else n_pass++;
            tick();
            exp_idx = 3'(k % 8);
            exp_oh  = 8'h01 << exp_idx;
            n_checks++;
            if (bus.grant_idx !== exp_idx || bus.grant !== exp_oh || bus.grant_valid !== 1'b1)
                $display("FAIL rot_grant k=%0d: idx=%0d grant=%h valid=%b, want %0d/%h/1",
                         k, bus.grant_idx, bus.grant, bus.grant_valid, exp_idx, exp_oh);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        bus.req = 8'h20;
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd5 || bus.grant !== 8'h20)
            $display("FAIL wrap_own5: idx=%0d grant=%h, want 5/20", bus.grant_idx, bus.grant);
        else n_pass++;
        bus.req  = 8'b0000_0101;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd0 || bus.grant !== 8'h01 || bus.grant_valid !== 1'b1)
            $display("FAIL wrap_to0: idx=%0d grant=%h, want 0/01", bus.grant_idx, bus.grant);
        else n_pass++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd2 || bus.grant !== 8'h04)
            $display("FAIL skip_to2: idx=%0d grant=%h, want 2/04", bus.grant_idx, bus.grant);
        else n_pass++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd0 || bus.grant !== 8'h01)
            $display("FAIL wrap_again0: idx=%0d grant=%h, want 0/01", bus.grant_idx, bus.grant);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        bus.req = 8'h28;
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd3 || bus.grant !== 8'h08)
            $display("FAIL to_grant3: idx=%0d grant=%h, want 3/08", bus.grant_idx, bus.grant);
        else n_pass++;
        held = 1;
        for (int i = 0; i < 40 && bus.grant_valid === 1'b1; i++) begin
            tick();
            if (bus.grant_valid === 1'b1) held++;
        end
        n_checks++;
        if (held != 16)
            $display("FAIL to_hold_len: held %0d cycles, want 16", held);
        else n_pass++;
        n_checks++;
        if (bus.timeout !== 1'b1 || bus.grant !== 8'h00)
            $display("FAIL to_pulse: to=%b grant=%h, want 1/00", bus.timeout, bus.grant);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b0)
            $display("FAIL to_clear: to=%b valid=%b, want 0/0", bus.timeout, bus.grant_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd5 || bus.grant !== 8'h20 || bus.timeout !== 1'b0)
            $display("FAIL to_next5: idx=%0d grant=%h to=%b, want 5/20/0",
                     bus.grant_idx, bus.grant, bus.timeout);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req = 8'h08;
        tick();
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd3)
            $display("FAIL sim_still_held: valid=%b idx=%0d, want 1/3", bus.grant_valid, bus.grant_idx);
        else n_pass++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_checks++;
        if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.grant !== 8'h00)
            $display("FAIL sim_release: valid=%b to=%b grant=%h, want 0/0/00",
                     bus.grant_valid, bus.timeout, bus.grant);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd3 || bus.grant_valid !== 1'b1)
            $display("FAIL sim_regrant3: idx=%0d valid=%b, want 3/1", bus.grant_idx, bus.grant_valid);
        else n_pass++;
        tick();
        bus.req = 8'h00;
        tick();
        n_checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant !== 8'h00 || bus.timeout !== 1'b0)
            $display("FAIL req_drop: valid=%b grant=%h to=%b, want 0/00/0",
                     bus.grant_valid, bus.grant, bus.timeout);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 8'h10;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd4 || bus.grant !== 8'h10)
            $display("FAIL mr_grant4: idx=%0d grant=%h, want 4/10", bus.grant_idx, bus.grant);
        else n_pass++;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0)
            $display("FAIL mr_drop: grant=%h valid=%b, want 00/0", bus.grant, bus.grant_valid);
        else n_pass++;
        rst_n   = 1'b1;
        bus.req = 8'h30;
        tick();
        n_checks++;
        if (bus.grant_idx !== 3'd4 || bus.grant !== 8'h10 || bus.grant_valid !== 1'b1)
            $display("FAIL mr_ptr_reset: idx=%0d grant=%h valid=%b, want 4/10/1",
                     bus.grant_idx, bus.grant, bus.grant_valid);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #2;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_timeout();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
